multi_cycle_ctrl: RTL

// - Multi-cycle sequencer; drives the Enable of every 32-bit latch register (IR, ADR/BDR, ALUoutDR, DBDR) plus PC, register-file and memory writes.
// - Sits between the instruction register output (opcode) / ALU flags and the datapath; one instruction = 2..5 cycles.
// - Also keeps cycle and retired-instruction counters for the debug display.

---
 rtl/cpu_defs_pkg.sv | 29 ++
 rtl/ctrl_counters.sv | 32 +++
 rtl/multi_cycle_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared decode constants for the multi-cycle controller: opcodes, state codes, pc_src codes.
package cpu_defs;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned PCSRC_W = 2;

  localparam logic [OPC_W-1:0] OP_LW   = 6'b110001;
  localparam logic [OPC_W-1:0] OP_SW   = 6'b110000;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OPC_W-1:0] OP_BNE  = 6'b110101;
  localparam logic [OPC_W-1:0] OP_J    = 6'b111000;
  localparam logic [OPC_W-1:0] OP_JAL  = 6'b111010;
  localparam logic [OPC_W-1:0] OP_JR   = 6'b111001;
  localparam logic [OPC_W-1:0] OP_HALT = 6'b111111;

  localparam logic [STATE_W-1:0] S_IF   = 3'b000;
  localparam logic [STATE_W-1:0] S_ID   = 3'b001;
  localparam logic [STATE_W-1:0] S_EXE  = 3'b010;
  localparam logic [STATE_W-1:0] S_MEM  = 3'b011;
  localparam logic [STATE_W-1:0] S_WB   = 3'b100;
  localparam logic [STATE_W-1:0] S_HALT = 3'b111;

  localparam logic [PCSRC_W-1:0] PC_PLUS4  = 2'b00;
  localparam logic [PCSRC_W-1:0] PC_BRANCH = 2'b01;
  localparam logic [PCSRC_W-1:0] PC_JUMP   = 2'b10;
  localparam logic [PCSRC_W-1:0] PC_RS     = 2'b11;

endpackage

// File: rtl/ctrl_counters.sv
// Debug counters: cycles while running and retired instructions, both wrap silently.
// Ports: CLK, Reset (async active-low), i_run (count cycle), i_retire (count
// instruction), o_cyc_cnt / o_ret_cnt (CNT_W-bit counts).
module ctrl_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             i_run,
  input  logic             i_retire,
  output logic [CNT_W-1:0] o_cyc_cnt,
  output logic [CNT_W-1:0] o_ret_cnt
);

  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_ret;

  // Free-running counters; natural overflow gives the modulo-2^CNT_W wrap.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_cyc <= '0;
      r_ret <= '0;
    end else begin
      if (i_run)    r_cyc <= r_cyc + CNT_W'(1);
      if (i_retire) r_ret <= r_ret + CNT_W'(1);
    end
  end

  assign o_cyc_cnt = r_cyc;
  assign o_ret_cnt = r_ret;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle instruction sequencer: steps IF/ID/EXE/MEM/WB per opcode and
// decodes the datapath latch, register-file, memory and PC enables from state.
// Ports: CLK, Reset (async active-low), opcode (IR[31:26]), zero (ALU flag);
// IRWre/ABWre/ALUWre/DBWre/RegWre/MemWre/PCWre enables, pc_src select,
// state code, halted, cyc_cnt / ret_cnt debug counters.
module multi_cycle_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  output logic               IRWre,
  output logic               ABWre,
  output logic               ALUWre,
  output logic               DBWre,
  output logic               RegWre,
  output logic               MemWre,
  output logic               PCWre,
  output logic [PCSRC_W-1:0] pc_src,
  output logic [STATE_W-1:0] state,
  output logic               halted,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [CNT_W-1:0]   ret_cnt
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic               w_is_jmp;
  logic               w_is_br;
  logic               w_is_mem;
  logic               w_taken;

  assign w_is_jmp = (opcode == OP_J) || (opcode == OP_JAL) || (opcode == OP_JR);
  assign w_is_br  = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign w_is_mem = (opcode == OP_LW) || (opcode == OP_SW);
  assign w_taken  = (opcode == OP_BEQ) ? zero : ~zero;

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) r_state <= S_IF;
    else        r_state <= w_next;
  end

  // Next-state logic; anything not a jump/branch/memory/halt op runs the ALU path
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:   w_next = S_ID;
      S_ID: begin
        if (w_is_jmp)               w_next = S_IF;
        else if (opcode == OP_HALT) w_next = S_HALT;
        else                        w_next = S_EXE;
      end
      S_EXE: begin
        if (w_is_br)       w_next = S_IF;
        else if (w_is_mem) w_next = S_MEM;
        else               w_next = S_WB;
      end
      S_MEM:  w_next = (opcode == OP_SW) ? S_IF : S_WB;
      S_WB:   w_next = S_IF;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  // Moore enable decode; gating with Reset drops every enable as soon as reset asserts
  always_comb begin
    IRWre  = 1'b0;
    ABWre  = 1'b0;
    ALUWre = 1'b0;
    DBWre  = 1'b0;
    RegWre = 1'b0;
    MemWre = 1'b0;
    PCWre  = 1'b0;
    pc_src = PC_PLUS4;
    if (Reset) begin
      case (r_state)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          if (w_is_jmp) begin
            PCWre  = 1'b1;
            RegWre = (opcode == OP_JAL);
            pc_src = (opcode == OP_JR) ? PC_RS : PC_JUMP;
          end else if (opcode != OP_HALT) begin
            ABWre = 1'b1;
          end
        end
        S_EXE: begin
          ALUWre = 1'b1;
          if (w_is_br) begin
            PCWre  = 1'b1;
            pc_src = w_taken ? PC_BRANCH : PC_PLUS4;
          end
        end
        S_MEM: begin
          if (opcode == OP_SW) begin
            MemWre = 1'b1;
            PCWre  = 1'b1;
          end else begin
            DBWre = 1'b1;
          end
        end
        S_WB: begin
          RegWre = 1'b1;
          PCWre  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state  = r_state;
  assign halted = (r_state == S_HALT);

  ctrl_counters #(.CNT_W(CNT_W)) u_counters (
    .CLK       (CLK),
    .Reset     (Reset),
    .i_run     (~halted),
    .i_retire  (PCWre),
    .o_cyc_cnt (cyc_cnt),
    .o_ret_cnt (ret_cnt)
  );

endmodule
